writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_W, 32, writeback data width.
REQ-002 Parameter ADDR_W, 5, register index width (32 registers).
REQ-003 Parameter QDEPTH, 4, load-return queue depth (power of two).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 alu_valid / alu_rd / alu_data  in  1 / ADDR_W / DATA_W  ALU result this cycle.
REQ-007 ld_issue / ld_issue_rd  in  1 / ADDR_W  load issued to memory; marks rd pending.
REQ-008 ld_valid / ld_rd / ld_data  in  1 / ADDR_W / DATA_W  load data return.
REQ-009 ld_ready  out  1  queue can accept a load return this cycle.
REQ-010 we / waddr / wbdata  out  1 / ADDR_W / DATA_W  register-file write port, registered.
REQ-011 pending  out  32  bit r = 1 while a load to register r is outstanding.
REQ-012 ovf  out  1  sticky: load return dropped because the queue was full.

Function
REQ-013 Every accepted write SHALL appear on we/waddr/wbdata exactly 1 cycle after acceptance.
REQ-014 ALU has absolute priority: alu_valid with alu_rd != 0 is accepted the same cycle, never stalled.
REQ-015 A load return SHALL be accepted into the FIFO when ld_valid and ld_ready are both 1.
REQ-016 FIFO head SHALL be written in any cycle with no accepted ALU write; one register write per cycle maximum.
REQ-017 Bypass: when the FIFO is empty, there is no accepted ALU write, and ld_valid = 1, the load is written directly (latency 1) without queueing.
REQ-018 ld_ready = 1 iff FIFO occupancy < QDEPTH; a push and pop in the same cycle at full SHALL NOT be allowed (ld_ready is based on registered occupancy only).
REQ-019 ld_valid while ld_ready = 0: data dropped, ovf set to 1 and held until reset.
REQ-020 Writes to rd = 0 (ALU or load) SHALL never assert we; load to x0 is consumed/discarded, and its pending bit is never set.
REQ-021 WAW squash: when an ALU write is accepted to rd, all queued entries with the same rd are marked dead; dead entries pop without asserting we.
REQ-022 pending[r] set on ld_issue with ld_issue_rd = r != 0; cleared when a load write to r (live or dead) leaves the unit.
REQ-023 Simultaneous set and clear of pending[r]: set wins.
REQ-024 pending[0] SHALL read 0 always.
REQ-025 Occupancy and pointers wrap modulo QDEPTH; occupancy width is clog2(QDEPTH)+1.
REQ-026 When we = 0, waddr and wbdata SHALL hold their previous values.

Reset
REQ-027 While reset = 0: we = 0, waddr = 0, wbdata = 0, pending = 0, ovf = 0, FIFO empty, ld_ready = 1.
REQ-028 Reset assertion mid-operation discards all queued entries immediately (asynchronous); the first write after reset release is accepted on the first rising edge with reset = 1.

Structure
REQ-029 Package wb_pkg SHALL hold DATA_W, ADDR_W, QDEPTH defaults and typedef wb_entry_t {rd, data, live}.
REQ-030 The FIFO with per-entry rd compare/kill SHALL be a sub-module, wb_fifo; arbitration, scoreboard, and output register remain in writeback_unit.

Verification
REQ-031 ALU-only: alu_valid, rd = 3, data = 0xDEADBEEF -> next cycle: we = 1, waddr = 3, wbdata = 0xDEADBEEF.
REQ-032 Collision: ALU rd = 4 plus load rd = 5, data = 0x55 in the same cycle -> cycle+1 writes r4; cycle+2 writes r5 = 0x55; pending[5] clears after cycle+2.
REQ-033 Fill: 4 load returns during 4 ALU cycles -> ld_ready = 0; a 5th ld_valid sets ovf = 1; after ALU stops, 4 writes drain in order.
REQ-034 WAW: load rd = 7 queued, then ALU rd = 7 data = 0x1 -> r7 written 0x1 once; dead entry pops with we = 0; pending[7] = 0 afterwards.
REQ-035 x0: ALU rd = 0 and ld_issue rd = 0 -> we stays 0, pending = 0.
REQ-036 Reset with 3 queued entries -> outputs 0 immediately, ld_ready = 1, no writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the queued load-return entry type for the writeback unit.
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int QDEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-return queue; an accepted ALU write can kill every stored entry that
// targets the same register so the stale load value is never written.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = QDEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_rd_i,
  output wb_entry_t         head_o,
  output logic              empty_o,
  output logic              full_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is not reset; emptiness is defined by the pointers and
  // count alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == kill_rd_i) mem_q[i].live <= 1'b0;
      end
    end
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results win, queued load returns fill
// idle slots, and a per-register scoreboard tracks outstanding loads.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int QDEPTH = wb_pkg::QDEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_issue,
  input  logic [ADDR_W-1:0]    ld_issue_rd,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [DATA_W-1:0]    wbdata,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 ovf
);

  localparam int NREG = 2 ** ADDR_W;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wbdata_q, wbdata_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              ovf_q;

  logic              alu_acc, ld_acc, ld_live, bypass, push, pop;
  logic              fifo_empty, fifo_full;
  logic              clr;
  logic [ADDR_W-1:0] clr_rd;
  wb_entry_t         push_entry, head;

  assign alu_acc  = alu_valid && (alu_rd != '0);
  assign ld_ready = !fifo_full;
  assign ld_acc   = ld_valid && ld_ready;
  // Loads to x0 are accepted and dropped here; they never occupy the queue.
  assign ld_live  = ld_acc && (ld_rd != '0);
  assign bypass   = ld_live && fifo_empty && !alu_acc;
  assign push     = ld_live && !bypass;
  assign pop      = !alu_acc && !fifo_empty;

  always_comb begin
    push_entry.rd   = ld_rd;
    push_entry.data = ld_data;
    push_entry.live = !(alu_acc && (alu_rd == ld_rd));
  end

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (alu_acc),
    .kill_rd_i    (alu_rd),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // if-chain can leave one unassigned and infer a latch.
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wbdata_d = wbdata_q;
    clr      = 1'b0;
    clr_rd   = '0;
    if (alu_acc) begin
      we_d     = 1'b1;
      waddr_d  = alu_rd;
      wbdata_d = alu_data;
    end else if (pop) begin
      clr    = 1'b1;
      clr_rd = head.rd;
      if (head.live) begin
        we_d     = 1'b1;
        waddr_d  = head.rd;
        wbdata_d = head.data;
      end
    end else if (bypass) begin
      clr      = 1'b1;
      clr_rd   = ld_rd;
      we_d     = 1'b1;
      waddr_d  = ld_rd;
      wbdata_d = ld_data;
    end
  end

  // Clear before set so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clr)                          pending_d = pending_d & ~(NREG'(1) << clr_rd);
    if (ld_issue && ld_issue_rd != '0) pending_d = pending_d | (NREG'(1) << ld_issue_rd);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wbdata_q  <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wbdata_q  <= wbdata_d;
      pending_q <= pending_d;
      if (ld_valid && !ld_ready) ovf_q <= 1'b1;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wbdata  = wbdata_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_writeback_unit;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, we, ovf;
  logic [4:0]  waddr;
  logic [31:0] wbdata, pending;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready), .we(we), .waddr(waddr), .wbdata(wbdata),
    .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_pend;
  bit          m_ovf, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wbdata;
  int          passed = 0;
  int          total = 0;

  task automatic model_reset();
    mq.delete();
    m_pend = '0; m_ovf = 0; m_we = 0; m_waddr = '0; m_wbdata = '0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
  task automatic cycle(input bit av, input int ard, input logic [31:0] ad,
                       input bit iss, input int ird,
                       input bit lv, input int lrd, input logic [31:0] ldd);
    bit    ready, alu_w, take;
    ment_t e;
    alu_valid = av; alu_rd = 5'(ard); alu_data = ad;
    ld_issue = iss; ld_issue_rd = 5'(ird);
    ld_valid = lv; ld_rd = 5'(lrd); ld_data = ldd;
    ready = (mq.size() < QD);
    alu_w = av && (ard != 0);
    if (lv && !ready) m_ovf = 1;
    take = lv && ready && (lrd != 0);
    if (alu_w) foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 0;
    m_we = 0;
    if (alu_w) begin
      m_we = 1; m_waddr = 5'(ard); m_wbdata = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_pend[e.rd] = 1'b0;
      if (e.live) begin m_we = 1; m_waddr = 5'(e.rd); m_wbdata = e.data; end
    end else if (take) begin
      m_we = 1; m_waddr = 5'(lrd); m_wbdata = ldd; m_pend[lrd] = 1'b0; take = 0;
    end
    if (take) mq.push_back('{rd: lrd, data: ldd, live: !(alu_w && ard == lrd)});
    if (iss && ird != 0) m_pend[ird] = 1'b1;
    @(posedge clk);
    #1;
    alu_valid = 0; ld_issue = 0; ld_valid = 0;
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    total++; if (we !== 1'b0)      $display("FAIL reset_we got %b exp 0", we); else passed++;
    total++; if (waddr !== 5'd0)   $display("FAIL reset_waddr got %0d exp 0", waddr); else passed++;
    total++; if (wbdata !== 32'd0) $display("FAIL reset_wbdata got %h exp 0", wbdata); else passed++;
    total++; if (pending !== 32'd0) $display("FAIL reset_pending got %h exp 0", pending); else passed++;
    total++; if (ovf !== 1'b0)     $display("FAIL reset_ovf got %b exp 0", ovf); else passed++;
    total++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b exp 1", ld_ready); else passed++;
  endtask

  task automatic test_alu_only();
    cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, '0);
    total++; if (we !== 1'b1)            $display("FAIL alu_we got %b exp 1", we); else passed++;
    total++; if (waddr !== 5'd3)         $display("FAIL alu_waddr got %0d exp 3", waddr); else passed++;
    total++; if (wbdata !== 32'hDEADBEEF) $display("FAIL alu_wbdata got %h exp deadbeef", wbdata); else passed++;
    idle();
    total++; if (we !== 1'b0)            $display("FAIL alu_idle_we got %b exp 0", we); else passed++;
    total++; if (waddr !== 5'd3 || wbdata !== 32'hDEADBEEF)
      $display("FAIL alu_hold got %0d/%h exp 3/deadbeef", waddr, wbdata); else passed++;
  endtask

  task automatic test_collision();
    cycle(0, 0, '0, 1, 5, 0, 0, '0);
    cycle(1, 4, 32'h44, 0, 0, 1, 5, 32'h55);
    total++; if (we !== 1'b1 || waddr !== 5'd4)
      $display("FAIL coll_alu got we=%b waddr=%0d exp 1/4", we, waddr); else passed++;
    total++; if (pending[5] !== 1'b1) $display("FAIL coll_pend_held got %b exp 1", pending[5]); else passed++;
    idle();
    total++; if (we !== 1'b1 || waddr !== 5'd5 || wbdata !== 32'h55)
      $display("FAIL coll_load got we=%b %0d/%h exp 1 5/55", we, waddr, wbdata); else passed++;
    total++; if (pending[5] !== 1'b0) $display("FAIL coll_pend_clr got %b exp 0", pending[5]); else passed++;
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < 4; i++) cycle(1, 10 + i, 32'(i), 0, 0, 1, 20 + i, 32'h100 + 32'(i));
    total++; if (ld_ready !== 1'b0) $display("FAIL fill_ready got %b exp 0", ld_ready); else passed++;
    total++; if (ovf !== 1'b0)      $display("FAIL fill_ovf_early got %b exp 0", ovf); else passed++;
    cycle(1, 14, 32'h4, 0, 0, 1, 24, 32'h999);
    total++; if (ovf !== 1'b1)      $display("FAIL fill_ovf got %b exp 1", ovf); else passed++;
    for (int i = 0; i < 4; i++) begin
      idle();
      total++;
      if (we !== 1'b1 || waddr !== 5'(20 + i) || wbdata !== 32'h100 + 32'(i))
        $display("FAIL drain_%0d got we=%b %0d/%h exp 1 %0d/%h", i, we, waddr, wbdata, 20 + i, 32'h100 + 32'(i));
      else passed++;
    end
    total++; if (ld_ready !== 1'b1) $display("FAIL drain_ready got %b exp 1", ld_ready); else passed++;
    total++; if (ovf !== 1'b1)      $display("FAIL ovf_sticky got %b exp 1", ovf); else passed++;
  endtask

  task automatic test_waw();
    cycle(0, 0, '0, 1, 7, 0, 0, '0);
    cycle(1, 1, 32'h11, 0, 0, 1, 7, 32'hAA);
    cycle(1, 7, 32'h1, 0, 0, 0, 0, '0);
    total++; if (we !== 1'b1 || waddr !== 5'd7 || wbdata !== 32'h1)
      $display("FAIL waw_alu got we=%b %0d/%h exp 1 7/1", we, waddr, wbdata); else passed++;
    idle();
    total++; if (we !== 1'b0)         $display("FAIL waw_dead_we got %b exp 0", we); else passed++;
    total++; if (pending[7] !== 1'b0) $display("FAIL waw_pend got %b exp 0", pending[7]); else passed++;
    total++; if (wbdata !== 32'h1)    $display("FAIL waw_hold got %h exp 1", wbdata); else passed++;
  endtask

  task automatic test_x0();
    cycle(1, 0, 32'h99, 1, 0, 0, 0, '0);
    total++; if (we !== 1'b0)       $display("FAIL x0_alu_we got %b exp 0", we); else passed++;
    total++; if (pending !== 32'd0) $display("FAIL x0_pending got %h exp 0", pending); else passed++;
    cycle(0, 0, '0, 0, 0, 1, 0, 32'h77);
    total++; if (we !== 1'b0)       $display("FAIL x0_ld_we got %b exp 0", we); else passed++;
    total++; if (ld_ready !== 1'b1) $display("FAIL x0_ready got %b exp 1", ld_ready); else passed++;
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) cycle(1, 2, 32'h2, (i == 0), 9, 1, 21 + i, 32'h200 + 32'(i));
    total++; if (pending[9] !== 1'b1) $display("FAIL rst_pre_pend got %b exp 1", pending[9]); else passed++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    total++; if (we !== 1'b0 || waddr !== 5'd0 || wbdata !== 32'd0)
      $display("FAIL rst_mid_out got we=%b %0d/%h exp 0 0/0", we, waddr, wbdata); else passed++;
    total++; if (pending !== 32'd0 || ovf !== 1'b0)
      $display("FAIL rst_mid_state got pend=%h ovf=%b exp 0/0", pending, ovf); else passed++;
    total++; if (ld_ready !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", ld_ready); else passed++;
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      total++; if (we !== 1'b0) $display("FAIL rst_post_we_%0d got %b exp 0", i, we); else passed++;
    end
    cycle(1, 6, 32'h66, 0, 0, 0, 0, '0);
    total++; if (we !== 1'b1 || waddr !== 5'd6)
      $display("FAIL rst_first_write got we=%b %0d exp 1 6", we, waddr); else passed++;
  endtask

  task automatic test_random();
    bit av, iss, lv;
    int ard, ird, lrd;
    for (int c = 0; c < 500; c++) begin
      av  = ($urandom_range(0, 1) == 1);
      ard = $urandom_range(0, 7);
      iss = ($urandom_range(0, 2) == 0);
      ird = $urandom_range(0, 7);
      lv  = ($urandom_range(0, 3) != 0);
      lrd = $urandom_range(0, 7);
      if (av && lv && lrd == ard) lrd = (ard + 1) % 8;
      cycle(av, ard, $urandom, iss, ird, lv, lrd, $urandom);
      total++; if (we !== m_we)         $display("FAIL rnd_we c%0d got %b exp %b", c, we, m_we); else passed++;
      total++; if (waddr !== m_waddr)   $display("FAIL rnd_waddr c%0d got %0d exp %0d", c, waddr, m_waddr); else passed++;
      total++; if (wbdata !== m_wbdata) $display("FAIL rnd_wbdata c%0d got %h exp %h", c, wbdata, m_wbdata); else passed++;
      total++; if (pending !== m_pend)  $display("FAIL rnd_pending c%0d got %h exp %h", c, pending, m_pend); else passed++;
      total++; if (ovf !== m_ovf)       $display("FAIL rnd_ovf c%0d got %b exp %b", c, ovf, m_ovf); else passed++;
      total++; if (ld_ready !== (mq.size() < QD))
        $display("FAIL rnd_ld_ready c%0d got %b exp %b", c, ld_ready, mq.size() < QD); else passed++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_alu_only();
    test_collision();
    test_fill_ovf();
    test_waw();
    test_x0();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
